tpu_seq_ctrl: RTL and testbench

- Sequencing controller for the TinyTapeout TPU (tt_um_tpu) datapath.
- Accepts a byte stream of weights and activations from the host pins and steers them into the operand buffer.
- Runs the N×N systolic matrix-multiply unit (MMU) for the required number of skewed cycles, then drains the 16-bit results to the host one byte at a time under a ready/valid handshake.
- Sits between the tt_um_tpu pin wrapper and the buffer/MMU datapath.

---
 rtl/tpu_pkg.sv | 44 ++++
 rtl/tpu_byte_counter.sv | 44 ++++
 rtl/tpu_seq_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_tpu_seq_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared types and sizing helpers for the TPU sequencing controller.
// The sizing helpers take the systolic dimension N so every block derives
// its counter widths from one place.
package tpu_pkg;

   // Controller phases: host load, MMU compute, result drain.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOAD    = 2'd1,
      ST_COMPUTE = 2'd2,
      ST_DRAIN   = 2'd3
   } tpu_state_e;

   // Weights occupy the low half of the operand buffer.
   localparam int WEIGHT_BASE = 0;

   // Activations start right after the N*N weights.
   function automatic int act_base(input int n);
      return n * n;
   endfunction

   // Operand buffer address width: 2*N*N bytes.
   function automatic int addr_w(input int n);
      return $clog2(2 * n * n);
   endfunction

   // Result element index width: N*N elements.
   function automatic int idx_w(input int n);
      return $clog2(n * n);
   endfunction

   // Skewed systolic schedule length.
   function automatic int compute_cycles(input int n);
      return 3 * n - 2;
   endfunction

   // Compute step index width, never narrower than one bit.
   function automatic int cyc_w(input int n);
      int c;
      c = $clog2(3 * n - 2);
      return (c < 1) ? 1 : c;
   endfunction

endpackage

// File: rtl/tpu_byte_counter.sv
// Enabled up-counter with terminal-count flag, synchronous clear and
// synchronous load. It saturates at MAX; the owner clears or reloads it.
// Priority: clear, then load, then increment.
module tpu_byte_counter #(
   parameter int W   = 3,
   parameter int MAX = 7
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic         ld_i,
   input  logic [W-1:0] ld_val_i,
   output logic [W-1:0] cnt_o,
   output logic         tc_o
);

   logic [W-1:0] cnt_q, cnt_d;

   assign tc_o  = (cnt_q == W'(MAX));
   assign cnt_o = cnt_q;

   // Next count: clear wins, then load, then a saturating increment.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (ld_i) begin
         cnt_d = ld_val_i;
      end else if (en_i && !tc_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/tpu_seq_ctrl.sv
// Sequencing controller for the tt_um_tpu datapath: loads 2*N*N operand
// bytes, runs the MMU for 3N-2 enabled steps, then drains the 16-bit
// results high byte first.
// Optional build macro TPU_OVERLAP_LOAD_EN: accept the next operand set
// during DRAIN through a separate preload counter.
//
// Handshakes: a byte moves only on a cycle where valid, ready and ena are
// all high at the rising clock edge; valid/ready may change freely otherwise,
// and neither side waits on the other combinationally.
module tpu_seq_ctrl
   import tpu_pkg::*;
#(
   parameter int N = 2,
   localparam int ADDR_W = addr_w(N),
   localparam int IDX_W  = idx_w(N),
   localparam int CYC_W  = cyc_w(N)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              load_valid,
   input  logic [7:0]        load_data,
   output logic              load_ready,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [7:0]        mem_wr_data,
   output logic              mmu_clear,
   output logic              mmu_en,
   output logic [CYC_W-1:0]  mmu_cycle,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IDX_W-1:0]  out_idx,
   output logic              out_hi,
   output logic              busy,
   output logic              done,
   output logic [1:0]        dbg_state
);

   localparam int LAST_ADDR = 2 * N * N - 1;
   localparam int LAST_CYC  = compute_cycles(N) - 1;

   tpu_state_e state_q, state_d;
   logic       done_q, done_d;
   logic       acc, xfer;

   logic              ld_en, ld_clr, ld_ld, ld_tc;
   logic [ADDR_W-1:0] ld_val, ld_cnt;
   logic              cyc_en, cyc_clr, cyc_tc;
   logic [CYC_W-1:0]  cyc_cnt;
   logic              k_en, k_clr, k_tc;
   logic [ADDR_W-1:0] k_cnt;

`ifdef TPU_OVERLAP_LOAD_EN
   logic              pre_en, pre_clr, pre_tc;
   logic [ADDR_W-1:0] pre_cnt;
   logic              pre_full_q, pre_full_d;
`endif

   // Handshake qualifiers kept outside the FSM block to avoid feedback.
`ifdef TPU_OVERLAP_LOAD_EN
   assign load_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD) ||
                       ((state_q == ST_DRAIN) && !pre_full_q);
   assign mem_wr_addr = (state_q == ST_DRAIN) ? pre_cnt : ld_cnt;
`else
   assign load_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
   assign mem_wr_addr = ld_cnt;
`endif
   assign out_valid   = (state_q == ST_DRAIN);
   assign acc         = load_valid & load_ready & ena;
   assign xfer        = out_valid & out_ready & ena;

   assign mem_wr_en   = acc;
   assign mem_wr_data = load_data;
   assign mmu_cycle   = cyc_cnt;
   assign out_idx     = k_cnt[ADDR_W-1:1];
   assign out_hi      = out_valid & ~k_cnt[0];
   assign busy        = (state_q != ST_IDLE);
   assign done        = done_q;
   assign dbg_state   = state_q;

   // Next-state, MMU strobes and counter controls.
   always_comb begin
      state_d   = state_q;
      done_d    = 1'b0;
      mmu_en    = 1'b0;
      mmu_clear = 1'b0;
      ld_en     = 1'b0;
      ld_clr    = 1'b0;
      ld_ld     = 1'b0;
      ld_val    = '0;
      cyc_en    = 1'b0;
      cyc_clr   = 1'b0;
      k_en      = 1'b0;
      k_clr     = 1'b0;
`ifdef TPU_OVERLAP_LOAD_EN
      pre_en     = 1'b0;
      pre_clr    = 1'b0;
      pre_full_d = pre_full_q;
`endif
      case (state_q)
         ST_IDLE, ST_LOAD: begin
            if (acc) begin
               ld_en = 1'b1;
               if (ld_tc) begin
                  ld_clr  = 1'b1;
                  state_d = ST_COMPUTE;
               end else begin
                  state_d = ST_LOAD;
               end
            end
         end
         ST_COMPUTE: begin
            // Gated by ena so a frozen cycle never counts as an MMU step.
            mmu_en    = ena;
            mmu_clear = ena && (cyc_cnt == '0);
            cyc_en    = ena;
            if (ena && cyc_tc) begin
               cyc_clr = 1'b1;
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            k_en = xfer;
`ifdef TPU_OVERLAP_LOAD_EN
            if (acc) begin
               pre_en = 1'b1;
               if (pre_tc) pre_full_d = 1'b1;
            end
`endif
            if (xfer && k_tc) begin
               k_clr  = 1'b1;
               done_d = 1'b1;
`ifdef TPU_OVERLAP_LOAD_EN
               // A byte accepted on this same cycle still counts.
               pre_clr    = 1'b1;
               pre_full_d = 1'b0;
               if (pre_full_q || (acc && pre_tc)) begin
                  state_d = ST_COMPUTE;
               end else begin
                  state_d = ST_LOAD;
                  ld_ld   = 1'b1;
                  ld_val  = pre_cnt + ADDR_W'(acc);
               end
`else
               state_d = ST_IDLE;
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and done-pulse registers; done self-clears even with ena low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

`ifdef TPU_OVERLAP_LOAD_EN
   // Marks a complete preloaded operand set during DRAIN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_full_q <= 1'b0;
      end else begin
         pre_full_q <= pre_full_d;
      end
   end

   tpu_byte_counter #(.W(ADDR_W), .MAX(LAST_ADDR)) u_pre_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (pre_clr),
      .en_i     (pre_en),
      .ld_i     (1'b0),
      .ld_val_i ('0),
      .cnt_o    (pre_cnt),
      .tc_o     (pre_tc)
   );
`endif

   tpu_byte_counter #(.W(ADDR_W), .MAX(LAST_ADDR)) u_load_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (ld_clr),
      .en_i     (ld_en),
      .ld_i     (ld_ld),
      .ld_val_i (ld_val),
      .cnt_o    (ld_cnt),
      .tc_o     (ld_tc)
   );

   tpu_byte_counter #(.W(CYC_W), .MAX(LAST_CYC)) u_cyc_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (cyc_clr),
      .en_i     (cyc_en),
      .ld_i     (1'b0),
      .ld_val_i ('0),
      .cnt_o    (cyc_cnt),
      .tc_o     (cyc_tc)
   );

   tpu_byte_counter #(.W(ADDR_W), .MAX(LAST_ADDR)) u_drain_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (k_clr),
      .en_i     (k_en),
      .ld_i     (1'b0),
      .ld_val_i ('0),
      .cnt_o    (k_cnt),
      .tc_o     (k_tc)
   );

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Directed bench for tpu_seq_ctrl with N=2: load, compute with ena gating,
// drain handshake, async reset mid-load, ignored inputs and, when built with
// TPU_OVERLAP_LOAD_EN, a preload during DRAIN.
module tb_tpu_seq_ctrl;

   localparam int N = 2;
`ifdef TPU_OVERLAP_LOAD_EN
   localparam bit OVL = 1'b1;
`else
   localparam bit OVL = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n, ena, load_valid, out_ready;
   logic [7:0] load_data;
   logic       load_ready, mem_wr_en, mmu_clear, mmu_en;
   logic [2:0] mem_wr_addr;
   logic [7:0] mem_wr_data;
   logic [1:0] mmu_cycle;
   logic       out_valid, out_hi, busy, done;
   logic [1:0] out_idx;
   logic [1:0] dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   int en_steps = 0;
   logic [7:0] exp_q[$];

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1);
   end

   tpu_seq_ctrl #(.N(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .load_ready  (load_ready),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_addr (mem_wr_addr),
      .mem_wr_data (mem_wr_data),
      .mmu_clear   (mmu_clear),
      .mmu_en      (mmu_en),
      .mmu_cycle   (mmu_cycle),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_idx     (out_idx),
      .out_hi      (out_hi),
      .busy        (busy),
      .done        (done),
      .dbg_state   (dbg_state)
   );

   task automatic check(input string tag, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", tag, act, exp);
      end
   endtask

   // Scoreboard: every buffer write must match the next expected byte.
   always @(negedge clk) begin
      #2;
      if (mmu_en === 1'b1) en_steps++;
      if (mem_wr_en === 1'b1) begin
         if (exp_q.size() == 0) check("wr_unexpected", 1, 0);
         else check("wr_data", mem_wr_data, exp_q.pop_front());
      end
   end

   // Driver: present one byte that must be accepted at addr.
   task automatic load_byte(input logic [7:0] d, input int addr);
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = d;
      exp_q.push_back(d);
      #1;
      check("ld_ready", load_ready, 1);
      check("ld_wr_en", mem_wr_en, 1);
      check("ld_addr", mem_wr_addr, addr);
   endtask

   // Driver: one enabled compute step with expected index.
   task automatic step_compute(input int cyc, input bit first);
      @(negedge clk);
      ena = 1'b1;
      #1;
      check("cmp_state", dbg_state, 2);
      check("cmp_mmu_en", mmu_en, 1);
      check("cmp_clear", mmu_clear, first);
      check("cmp_cycle", mmu_cycle, cyc);
      check("cmp_ld_ready", load_ready, 0);
      check("cmp_wr_en", mem_wr_en, 0);
   endtask

   initial begin
      int k;
      rst_n = 1'b0; ena = 1'b1; load_valid = 1'b0; load_data = 8'h00; out_ready = 1'b0;
      #1;
      // Reset state.
      check("rst_state", dbg_state, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_hi", out_hi, 0);
      check("rst_out_idx", out_idx, 0);
      check("rst_mmu_en", mmu_en, 0);
      check("rst_mmu_clear", mmu_clear, 0);
      check("rst_mmu_cycle", mmu_cycle, 0);
      check("rst_wr_en", mem_wr_en, 0);
      check("rst_wr_addr", mem_wr_addr, 0);
      check("rst_ld_ready", load_ready, 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // out_ready in IDLE has no effect.
      @(negedge clk); out_ready = 1'b1; #1;
      check("idle_out_valid", out_valid, 0);
      @(negedge clk); #1;
      check("idle_state", dbg_state, 0);
      check("idle_done", done, 0);
      check("idle_out_hi", out_hi, 0);
      out_ready = 1'b0;

      // Basic load of 0x01..0x08, load_valid stays high into COMPUTE.
      for (int i = 0; i < 8; i++) load_byte(8'(i + 1), i);

      // Compute: step 0, three frozen cycles, then steps 1..3.
      step_compute(0, 1'b1);
      repeat (3) begin
         @(negedge clk); ena = 1'b0; #1;
         check("frz_mmu_en", mmu_en, 0);
         check("frz_clear", mmu_clear, 0);
         check("frz_cycle", mmu_cycle, 1);
         check("frz_state", dbg_state, 2);
      end
      for (int s = 1; s < 4; s++) step_compute(s, 1'b0);

      // Drain with out_ready toggling 1,0,1,...; no preload in main flow.
      for (int j = 0; j < 15; j++) begin
         @(negedge clk);
         load_valid = !OVL;
         out_ready  = (j % 2 == 0);
         #1;
         k = (j + 1) / 2;
         check("drn_state", dbg_state, 3);
         check("drn_valid", out_valid, 1);
         check("drn_idx", out_idx, k >> 1);
         check("drn_hi", out_hi, ((k & 1) == 0) ? 1 : 0);
         check("drn_done", done, 0);
         check("drn_ld_ready", load_ready, OVL);
         check("drn_wr_en", mem_wr_en, 0);
      end
      @(negedge clk); out_ready = 1'b0; load_valid = 1'b0; #1;
      check("end_done", done, 1);
      check("end_state", dbg_state, OVL ? 1 : 0);
      check("end_busy", busy, OVL);
      check("end_out_valid", out_valid, 0);
      check("en_steps", en_steps, 4);
      @(negedge clk); #1;
      check("end_done_clear", done, 0);

      // Async reset after five bytes; next load restarts at address 0.
      for (int i = 0; i < 5; i++) load_byte(8'hA0 + 8'(i), i);
      @(negedge clk); load_valid = 1'b0; #1;
      rst_n = 1'b0; #1;
      check("arst_state", dbg_state, 0);
      check("arst_busy", busy, 0);
      check("arst_addr", mem_wr_addr, 0);
      check("arst_wr_en", mem_wr_en, 0);
      check("arst_mmu_en", mmu_en, 0);
      check("arst_out_valid", out_valid, 0);
      check("arst_done", done, 0);
      @(negedge clk); rst_n = 1'b1;
      load_byte(8'h55, 0);

`ifdef TPU_OVERLAP_LOAD_EN
      for (int i = 1; i < 8; i++) load_byte(8'h55 + 8'(i), i);
      for (int s = 0; s < 4; s++) step_compute(s, s == 0);
      // Preload a full operand set while draining.
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         out_ready = 1'b1; load_valid = 1'b1; load_data = 8'hC0 + 8'(j);
         exp_q.push_back(load_data);
         #1;
         check("ovl_idx", out_idx, j >> 1);
         check("ovl_hi", out_hi, ((j & 1) == 0) ? 1 : 0);
         check("ovl_ld_ready", load_ready, 1);
         check("ovl_wr_en", mem_wr_en, 1);
         check("ovl_addr", mem_wr_addr, j);
      end
      @(negedge clk); out_ready = 1'b0; load_valid = 1'b0; #1;
      check("ovl_done", done, 1);
      check("ovl_state", dbg_state, 2);
      check("ovl_mmu_en", mmu_en, 1);
      check("ovl_clear", mmu_clear, 1);
      check("ovl_cycle", mmu_cycle, 0);
`else
      @(negedge clk); load_valid = 1'b0; #1;
      check("reload_state", dbg_state, 1);
      check("reload_addr", mem_wr_addr, 1);
`endif

      @(negedge clk); #3;
      check("exp_q_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
